// File: rtl/sound_sequencer.sv
// rtl/sound_sequencer.sv - fixed-priority multi-event sound-effect sequencer
// Plays a per-event list of tone/duration notes, timed by an external tick.
module sound_sequencer #(
    parameter int NUM_EVENTS = 4,
    parameter int MAX_NOTES  = 4,
    parameter int TONE_W     = 4,
    parameter int DUR_W      = 4,
    parameter int GAP_TICKS  = 1,
    parameter int PREEMPT    = 1,
    localparam int EW = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   tick,
    input  logic [NUM_EVENTS-1:0]                  event_req,
    input  logic [NUM_EVENTS*MAX_NOTES*TONE_W-1:0] tone_table,
    input  logic [NUM_EVENTS*MAX_NOTES*DUR_W-1:0]  dur_table,
    output logic                                   play,
    output logic [TONE_W-1:0]                      tone,
    output logic                                   busy,
    output logic [EW-1:0]                          cur_event,
    output logic                                   done
);
    localparam int NW = (MAX_NOTES > 1) ? $clog2(MAX_NOTES) : 1;
    localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST  = (GAP_TICKS > 0) ? GW'(GAP_TICKS - 1) : '0;
    localparam logic [NW-1:0] NOTE_LAST = NW'(MAX_NOTES - 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_GAP} state_t;

    state_t                  state_q, state_d;
    logic [NUM_EVENTS-1:0]   pending_q, pending_d;
    logic [EW-1:0]           cur_event_q, cur_event_d;
    logic [NW-1:0]           note_q, note_d;
    logic [DUR_W-1:0]        tick_cnt_q, tick_cnt_d;
    logic [GW-1:0]           gap_cnt_q, gap_cnt_d;
    logic [TONE_W-1:0]       tone_q, tone_d;
    logic                    done_q, done_d;

    logic [TONE_W-1:0]       tone_arr [NUM_EVENTS][MAX_NOTES];
    logic [DUR_W-1:0]        dur_arr  [NUM_EVENTS][MAX_NOTES];

    logic [NUM_EVENTS-1:0]   req_all;
    logic [EW-1:0]           sel;
    logic [NW-1:0]           note_inc;
    logic [DUR_W-1:0]        cur_dur;
    logic [DUR_W-1:0]        next_dur;
    logic                    last_note;
    logic                    note_end;
    logic                    preempt;
    logic                    launch;

    for (genvar e = 0; e < NUM_EVENTS; e++) begin : g_evt
        for (genvar n = 0; n < MAX_NOTES; n++) begin : g_note
            assign tone_arr[e][n] = tone_table[(e*MAX_NOTES+n)*TONE_W +: TONE_W];
            assign dur_arr[e][n]  = dur_table[(e*MAX_NOTES+n)*DUR_W +: DUR_W];
        end
    end

    always_comb begin
        req_all = pending_q | event_req;
        sel     = '0;
        for (int i = NUM_EVENTS - 1; i >= 0; i--) begin
            if (req_all[i]) sel = EW'(i);
        end
        last_note = (note_q == NOTE_LAST);
        // note_inc saturates so the next-note lookup never leaves the table
        note_inc  = last_note ? note_q : note_q + NW'(1);
        cur_dur   = dur_arr[cur_event_q][note_q];
        next_dur  = dur_arr[cur_event_q][note_inc];
        note_end  = (tick_cnt_q == cur_dur - DUR_W'(1));
        preempt   = (PREEMPT != 0) && (req_all != '0) && (sel < cur_event_q);

        state_d     = state_q;
        pending_d   = req_all;
        cur_event_d = cur_event_q;
        note_d      = note_q;
        tick_cnt_d  = tick_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        tone_d      = tone_q;
        done_d      = 1'b0;
        launch      = 1'b0;

        case (state_q)
            S_IDLE: launch = (req_all != '0);
            S_PLAY: begin
                if (preempt) begin
                    launch = 1'b1;
                end else if (tick) begin
                    if (!note_end) begin
                        tick_cnt_d = tick_cnt_q + DUR_W'(1);
                    end else if (last_note || next_dur == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else if (GAP_TICKS > 0) begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end else begin
                        note_d     = note_inc;
                        tick_cnt_d = '0;
                        tone_d     = tone_arr[cur_event_q][note_inc];
                    end
                end
            end
            S_GAP: begin
                if (preempt) begin
                    launch = 1'b1;
                end else if (tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        state_d    = S_PLAY;
                        note_d     = note_inc;
                        tick_cnt_d = '0;
                        tone_d     = tone_arr[cur_event_q][note_inc];
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A preempting launch behaves exactly like a launch from idle
        if (launch) begin
            pending_d[sel] = 1'b0;
            cur_event_d    = sel;
            note_d         = '0;
            tick_cnt_d     = '0;
            if (dur_arr[sel][0] == '0) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = S_PLAY;
                tone_d  = tone_arr[sel][0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            cur_event_q <= '0;
            note_q      <= '0;
            tick_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            tone_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            cur_event_q <= cur_event_d;
            note_q      <= note_d;
            tick_cnt_q  <= tick_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            tone_q      <= tone_d;
            done_q      <= done_d;
        end
    end

    assign play      = (state_q == S_PLAY);
    assign busy      = (state_q != S_IDLE);
    assign tone      = tone_q;
    assign cur_event = cur_event_q;
    assign done      = done_q;

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Multi-channel sound-effect sequencer for the game audio path. It accepts one-cycle event requests from game logic (character hit, bubble hit, bubble pop, level clear, …) and arbitrates between them by fixed priority. The winning event plays a per-event sequence of up to MAX_NOTES notes, each with its own tone and duration, timed by an external tick. Its play/tone outputs drive the tone generator directly.

## Interface
- NUM_EVENTS, 4: number of event channels; index 0 has the highest priority.
- MAX_NOTES, 4: note slots per event.
- TONE_W, 4: tone code width.
- DUR_W, 4: note duration width, in ticks.
- GAP_TICKS, 1: silent ticks between notes of one sequence; 0 means no gap.
- PREEMPT, 1: when 1, a higher-priority request aborts the current sequence.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-cycle timebase pulse; the only duration unit.
- event_req  in  NUM_EVENTS  one-cycle request pulses, one bit per event.
- tone_table  in  NUM_EVENTS*MAX_NOTES*TONE_W  tone of event e, note n, at bits [(e*MAX_NOTES+n)*TONE_W +: TONE_W].
- dur_table  in  NUM_EVENTS*MAX_NOTES*DUR_W  duration of each note, same layout; 0 marks end of sequence.
- play  out  1  tone generator enable.
- tone  out  TONE_W  current tone code.
- busy  out  1  high whenever the FSM is not IDLE.
- cur_event  out  max(1,$clog2(NUM_EVENTS))  index of the sequence in progress.
- done  out  1  one-cycle pulse when a sequence finishes or is discarded.

## Operation
- pending[NUM_EVENTS] register: event_req bits are OR'd in every cycle. A bit clears when its event is launched. A request for an event that is already pending is absorbed (no counting).
- FSM states: IDLE, PLAY, GAP.
- IDLE:
  - If pending or event_req is nonzero, select the lowest set index e. Load cur_event=e, note=0, tick_cnt=0, and clear pending[e].
  - If dur(e,0)==0, stay in IDLE, pulse done, and play nothing.
  - Otherwise go to PLAY.
- PLAY: play=1, tone=tone(e,note). Each tick increments tick_cnt. On the tick where tick_cnt==dur(e,note)-1, the note ends:
  - If note==MAX_NOTES-1 or dur(e,note+1)==0, the sequence ends: go to IDLE and pulse done.
  - Else, if GAP_TICKS>0, go to GAP; else go to PLAY with note+1 and tick_cnt=0.
- GAP: play=0, tone holds the last note's tone. After GAP_TICKS ticks, go to PLAY with note+1 and tick_cnt=0.
- Preemption (PREEMPT=1, state PLAY or GAP): a request or pending bit with index < cur_event aborts the current sequence.
  - The aborted sequence is dropped, not re-queued, and done is not pulsed.
  - The next cycle starts the new event at note 0, following IDLE's launch rules, including the empty-sequence case.
- A request with index ≥ cur_event while busy is only latched in pending. This includes a re-request of the current event, which replays after completion.
- With PREEMPT=0, every request while busy is latched.
- Widths: tick_cnt is DUR_W bits; note index is max(1,$clog2(MAX_NOTES)) bits; the gap counter is max(1,$clog2(GAP_TICKS+1)) bits. No counter wraps: a counter always terminates at its compare value.
- The tables are sampled live. They must be held constant while busy; changes made mid-sequence are undefined.

## Timing
- Reset values: play=0, tone=0, busy=0, cur_event=0, done=0, pending=0, state=IDLE. A reset mid-sequence aborts immediately: no done pulse, and pending is cleared.
- Launch latency: a request in cycle N with the FSM in IDLE gives busy=1, play=1, tone=tone(e,0) in cycle N+1.
- Ticks are counted only in PLAY and GAP. A tick in the launch cycle N is ignored.
- Note length: exactly dur ticks. The output changes in the cycle after the terminating tick.
- done is asserted in the cycle after the terminating tick, together with busy=0 and play=0. If pending is nonzero at that point, the next launch occurs in the cycle after done, so there is a minimum of one IDLE cycle between sequences.
- Simultaneous events:
  - Several requests in one cycle: the lowest index launches and the rest stay pending.
  - A request in the same cycle as a sequence end is latched and launches after the IDLE cycle.
- tone and cur_event are registered outputs; there are no combinational paths from any input to any output.

## Test plan
- Single event: event 1 with tones {3,5}, durations {2,1,0,0}, GAP_TICKS=1, tick every 4 cycles, req[1] pulsed at cycle 10. Required: play=1 and tone=3 from cycle 11; two ticks of tone 3, one silent gap tick, one tick of tone 5; then done=1 and busy=0 in the cycle after that last tick.
- Priority: req=4'b0110 in the same cycle. Required: event 1 plays to completion, done pulses, IDLE for one cycle, then event 2 plays.
- Preemption: event 3 playing note 1 when req[0] arrives. Required: the next cycle shows cur_event=0 and tone=tone(0,0); event 3 never resumes and no done pulse is issued for it. With PREEMPT=0 in the same scenario, event 3 completes first, then event 0 plays.
- Empty sequence: dur(2,0)=0, req[2] pulsed. Required: done for one cycle, play stays 0, busy stays 0.
- Re-request and reset: req[1] pulsed again during event 1's second note. Required: event 1 replays in full after its done. A reset asserted mid-note clears play, busy and pending in the next cycle, with no done pulse.
- Full-length sequence: MAX_NOTES=4 with all durations nonzero (e.g. 15). Required: the sequence ends after note 3 without the note index wrapping, and a 15-tick note lasts exactly 15 ticks.
